// File: rtl/wb_sram_responder.sv
// Wishbone classic single-port SRAM responder.
// FSM IDLE -> WAIT (WAIT_STATES cycles) -> RESP, with a one-cycle registered ack.
// Writes commit and reads are captured on the edge that enters RESP.
// Optional feature: define WB_ERR_EN to add bus__err. Out-of-range requests then
// answer with err instead of ack.

module wb_sram_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [29:0] BASE        = 30'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus__cyc,
  input  logic        bus__stb,
  input  logic        bus__we,
  input  logic [29:0] bus__adr,
  input  logic [3:0]  bus__sel,
  input  logic [31:0] bus__dat_w,
  output logic [31:0] bus__dat_r,
  output logic        bus__ack
`ifdef WB_ERR_EN
  ,
  output logic        bus__err
`endif
);

  localparam int unsigned Words   = 1 << DEPTH_LOG2;
  // Counter value on the final WAIT cycle; unused when WAIT_STATES is 0.
  localparam logic [2:0]  LastCnt = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

  state_t                state;
  logic [2:0]            wait_cnt;
  logic [31:0]           mem [Words];

  logic                  req;
  logic                  in_range;
  logic                  enter_resp;
  logic                  mem_we;
  logic                  resp_ok;
  logic [DEPTH_LOG2-1:0] idx;

  // Request decode and the single "entering RESP" strobe that drives both write and read.
  always_comb begin
    req        = bus__cyc & bus__stb;
    in_range   = (bus__adr[29:DEPTH_LOG2] == BASE[29:DEPTH_LOG2]);
    idx        = bus__adr[DEPTH_LOG2-1:0];
    enter_resp = 1'b0;
    if (req) begin
      if (state == StIdle && WAIT_STATES == 0) begin
        enter_resp = 1'b1;
      end else if (state == StWait && wait_cnt == LastCnt) begin
        enter_resp = 1'b1;
      end
    end
    // Gating by rst keeps a write from committing if reset is held across the edge.
    mem_we = enter_resp & in_range & bus__we & ~rst;
`ifdef WB_ERR_EN
    resp_ok = in_range;
`else
    resp_ok = 1'b1;
`endif
  end

  // Byte-lane masked memory write; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus__sel[b]) begin
          mem[idx][8*b +: 8] <= bus__dat_w[8*b +: 8];
        end
      end
    end
  end

  // Responder FSM with registered ack/err/dat_r, all cleared outside RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      wait_cnt   <= 3'd0;
      bus__ack   <= 1'b0;
      bus__dat_r <= 32'd0;
`ifdef WB_ERR_EN
      bus__err   <= 1'b0;
`endif
    end else begin
      bus__ack   <= 1'b0;
      bus__dat_r <= 32'd0;
`ifdef WB_ERR_EN
      bus__err   <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (req) begin
            wait_cnt <= 3'd0;
            state    <= (WAIT_STATES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          // Initiator abandoned the cycle: drop back without responding.
          if (!req) begin
            state <= StIdle;
          end else if (wait_cnt == LastCnt) begin
            state <= StResp;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        StResp: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase

      if (enter_resp) begin
        bus__ack <= resp_ok;
`ifdef WB_ERR_EN
        bus__err <= ~in_range;
`endif
        if (!bus__we && in_range) begin
          bus__dat_r <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Self-checking bench for wb_sram_responder: WAIT_STATES=2 main instance plus a
// WAIT_STATES=0 instance for the back-to-back pattern. Define WB_ERR_EN to test err.

module tb_wb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        cyc, stb, we;
  logic [29:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w, dat_r;
  logic        ack, err;

  logic        z_cyc, z_stb, z_we;
  logic [29:0] z_adr;
  logic [3:0]  z_sel;
  logic [31:0] z_dat_w, z_dat_r;
  logic        z_ack, z_err;

  int checks = 0;
  int errors = 0;

  // Reference memory for words 0..15 of the main instance.
  logic [31:0] ref_mem [16];

  wb_sram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2), .BASE(30'd0)) dut (
    .clk(clk), .rst(rst), .bus__cyc(cyc), .bus__stb(stb), .bus__we(we), .bus__adr(adr),
    .bus__sel(sel), .bus__dat_w(dat_w), .bus__dat_r(dat_r), .bus__ack(ack)
`ifdef WB_ERR_EN
    , .bus__err(err)
`endif
  );

  wb_sram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .BASE(30'd0)) dut0 (
    .clk(clk), .rst(rst), .bus__cyc(z_cyc), .bus__stb(z_stb), .bus__we(z_we), .bus__adr(z_adr),
    .bus__sel(z_sel), .bus__dat_w(z_dat_w), .bus__dat_r(z_dat_r), .bus__ack(z_ack)
`ifdef WB_ERR_EN
    , .bus__err(z_err)
`endif
  );

`ifndef WB_ERR_EN
  assign err   = 1'b0;
  assign z_err = 1'b0;
`endif

  // Byte-lane merge rule: selected bytes come from the new data.
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One classic transfer on the main instance. Called 1 time unit after a rising edge.
  // lat = number of edges from request to the ack/err cycle (-1 on timeout).
  // bad flags ack+err together or nonzero dat_r outside the response cycle.
  task automatic xfer(input logic w, input logic [29:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd, output int lat,
                      output logic got_err, output logic bad);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    lat = -1; rd = 32'd0; got_err = 1'b0; bad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        lat = i; rd = dat_r; got_err = err;
        if (ack && err) bad = 1'b1;
        break;
      end
      if (dat_r !== 32'd0) bad = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    if (ack !== 1'b0 || err !== 1'b0 || dat_r !== 32'd0) bad = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; dat_w = '0;
    z_cyc = 0; z_stb = 0; z_we = 0; z_adr = '0; z_sel = '0; z_dat_w = '0;
    #2;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || dat_r !== 32'd0 || z_ack !== 1'b0 || z_dat_r !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b err=%b dat_r=%h z_ack=%b z_dat_r=%h, want all 0",
               ack, err, dat_r, z_ack, z_dat_r);
    end
    // Requests during reset must be ignored.
    cyc = 1; stb = 1; z_cyc = 1; z_stb = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0 || z_ack !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_ack: ack=%b z_ack=%b, want 0", ack, z_ack);
      end
    end
    cyc = 0; stb = 0; z_cyc = 0; z_stb = 0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] rd; int lat; logic ge, bad;
    xfer(1'b1, 30'd5, 4'hF, 32'hDEADBEEF, rd, lat, ge, bad);
    ref_mem[5] = 32'hDEADBEEF;
    checks++;
    if (lat !== 3 || ge !== 1'b0 || bad !== 1'b0) begin
      errors++;
      $display("FAIL basic_write: lat=%0d err=%b bad=%b, want lat=3 err=0 bad=0", lat, ge, bad);
    end
    xfer(1'b0, 30'd5, 4'hF, 32'h0, rd, lat, ge, bad);
    checks++;
    if (lat !== 3 || rd !== 32'hDEADBEEF || bad !== 1'b0) begin
      errors++;
      $display("FAIL basic_read: lat=%0d dat_r=%h bad=%b, want lat=3 dat_r=deadbeef", lat, rd, bad);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lat; logic ge, bad;
    xfer(1'b1, 30'd5, 4'h5, 32'h11223344, rd, lat, ge, bad);
    ref_mem[5] = merge(ref_mem[5], 32'h11223344, 4'h5);
    xfer(1'b0, 30'd5, 4'hF, 32'h0, rd, lat, ge, bad);
    checks++;
    if (rd !== 32'hDE22BE44 || lat !== 3) begin
      errors++;
      $display("FAIL byte_lanes: dat_r=%h lat=%0d, want de22be44 lat=3", rd, lat);
    end
    xfer(1'b1, 30'd5, 4'h0, 32'hFFFFFFFF, rd, lat, ge, bad);
    checks++;
    if (lat !== 3 || bad !== 1'b0) begin
      errors++;
      $display("FAIL sel_zero_ack: lat=%0d bad=%b, want lat=3", lat, bad);
    end
    xfer(1'b0, 30'd5, 4'hF, 32'h0, rd, lat, ge, bad);
    checks++;
    if (rd !== ref_mem[5]) begin
      errors++;
      $display("FAIL sel_zero_data: dat_r=%h, want %h", rd, ref_mem[5]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d; int lat; logic ge, bad; logic [29:0] a; logic [3:0] s; logic w;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      xfer(1'b1, 30'(i), 4'hF, d, rd, lat, ge, bad);
      ref_mem[i] = d;
    end
    for (int n = 0; n < 40; n++) begin
      a = 30'($urandom_range(15, 0));
      s = 4'($urandom);
      d = $urandom;
      w = 1'($urandom);
      xfer(w, a, s, d, rd, lat, ge, bad);
      checks++;
      if (lat !== 3 || ge !== 1'b0 || bad !== 1'b0) begin
        errors++;
        $display("FAIL rand_proto[%0d]: lat=%0d err=%b bad=%b, want lat=3", n, lat, ge, bad);
      end
      if (w) begin
        ref_mem[a[3:0]] = merge(ref_mem[a[3:0]], d, s);
      end else begin
        checks++;
        if (rd !== ref_mem[a[3:0]]) begin
          errors++;
          $display("FAIL rand_read[%0d] adr=%0d: dat_r=%h, want %h", n, a, rd, ref_mem[a[3:0]]);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat; logic ge, bad; int acks;
    acks = 0;
    cyc = 1; stb = 1; we = 1; adr = 30'd5; sel = 4'hF; dat_w = 32'h0BADF00D;
    @(posedge clk); #1;
    stb = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack || err) acks++;
      @(posedge clk); #1;
    end
    cyc = 0; we = 0;
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL abort_ack: saw %0d acks, want 0", acks);
    end
    xfer(1'b0, 30'd5, 4'hF, 32'h0, rd, lat, ge, bad);
    checks++;
    if (rd !== ref_mem[5]) begin
      errors++;
      $display("FAIL abort_data: dat_r=%h, want %h", rd, ref_mem[5]);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; int lat; logic ge, bad; int acks;
    acks = 0;
    cyc = 1; stb = 1; we = 1; adr = 30'd6; sel = 4'hF; dat_w = ~ref_mem[6];
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    if (ack) acks++;
    // Hold reset across the edge that would have entered RESP.
    @(posedge clk); #1;
    if (ack) acks++;
    cyc = 0; stb = 0; we = 0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL rst_wait_ack: saw %0d acks, want 0", acks);
    end
    xfer(1'b0, 30'd6, 4'hF, 32'h0, rd, lat, ge, bad);
    checks++;
    if (rd !== ref_mem[6] || lat !== 3) begin
      errors++;
      $display("FAIL rst_wait_data: dat_r=%h lat=%0d, want %h lat=3", rd, lat, ref_mem[6]);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ack; logic [31:0] exp_dat;
    cyc = 1; stb = 1; we = 0; adr = 30'd7; sel = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      exp_ack = (c % 4 == 0);
      exp_dat = exp_ack ? ref_mem[7] : 32'd0;
      checks++;
      if (ack !== exp_ack || dat_r !== exp_dat) begin
        errors++;
        $display("FAIL b2b_cycle%0d: ack=%b dat_r=%h, want ack=%b dat_r=%h",
                 c, ack, dat_r, exp_ack, exp_dat);
      end
    end
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int lat; logic ge, bad;
    xfer(1'b0, 30'h400, 4'hF, 32'h0, rd, lat, ge, bad);
`ifdef WB_ERR_EN
    checks++;
    if (lat !== 3 || ge !== 1'b1 || rd !== 32'd0 || bad !== 1'b0) begin
      errors++;
      $display("FAIL oor_read: lat=%0d err=%b dat_r=%h bad=%b, want lat=3 err=1 dat_r=0",
               lat, ge, rd, bad);
    end
`else
    checks++;
    if (lat !== 3 || ge !== 1'b0 || rd !== 32'd0 || bad !== 1'b0) begin
      errors++;
      $display("FAIL oor_read: lat=%0d err=%b dat_r=%h bad=%b, want lat=3 err=0 dat_r=0",
               lat, ge, rd, bad);
    end
`endif
    xfer(1'b1, 30'h405, 4'hF, ~ref_mem[5], rd, lat, ge, bad);
    xfer(1'b0, 30'd5, 4'hF, 32'h0, rd, lat, ge, bad);
    checks++;
    if (rd !== ref_mem[5]) begin
      errors++;
      $display("FAIL oor_write_dropped: dat_r=%h, want %h", rd, ref_mem[5]);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] v; logic exp_ack; logic [31:0] exp_dat;
    v = $urandom;
    z_cyc = 1; z_stb = 1; z_we = 1; z_adr = 30'd3; z_sel = 4'hF; z_dat_w = v;
    @(posedge clk); #1;
    z_cyc = 0; z_stb = 0; z_we = 0;
    checks++;
    if (z_ack !== 1'b1) begin
      errors++;
      $display("FAIL zw_write_ack: ack=%b, want 1", z_ack);
    end
    @(posedge clk); #1;
    z_cyc = 1; z_stb = 1;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      exp_ack = (c % 2 == 0);
      exp_dat = exp_ack ? v : 32'd0;
      checks++;
      if (z_ack !== exp_ack || z_dat_r !== exp_dat || z_err !== 1'b0) begin
        errors++;
        $display("FAIL zw_cycle%0d: ack=%b dat_r=%h err=%b, want ack=%b dat_r=%h",
                 c, z_ack, z_dat_r, z_err, exp_ack, exp_dat);
      end
    end
    z_cyc = 0; z_stb = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_random();
    test_abort();
    test_reset_in_wait();
    test_back_to_back();
    test_out_of_range();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a task ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/wb_sram_responder.md
WB_SRAM_RESPONDER -- requirements
Module: wb_sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit memory words.
REQ-002 SHALL have parameter WAIT_STATES, default 2, wait cycles inserted before ack; legal range 0..6.
REQ-003 SHALL have parameter BASE, default 0, 30-bit word base address of the window, aligned to 2**DEPTH_LOG2.
REQ-004 SHALL have one clock and asynchronous, active-high reset: clk and rst.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 bus__cyc  input  1  Wishbone cycle valid.
REQ-008 bus__stb  input  1  Wishbone strobe.
REQ-009 bus__we  input  1  write enable.
REQ-010 bus__adr  input  30  word address.
REQ-011 bus__sel  input  4  byte lane select, bit n selects bits 8n+7:8n.
REQ-012 bus__dat_w  input  32  write data.
REQ-013 bus__dat_r  output  32  read data, registered.
REQ-014 bus__ack  output  1  transfer acknowledge, registered.

Function
REQ-015 SHALL implement a Wishbone classic responder FSM with states IDLE, WAIT and RESP.
REQ-016 In IDLE, a sampled request (bus__cyc and bus__stb both 1) SHALL go to WAIT if WAIT_STATES>0, else to RESP.
REQ-017 WAIT SHALL count exactly WAIT_STATES cycles in a 3-bit counter, then enter RESP; ack is high while in RESP.
REQ-018 Latency: ack SHALL assert exactly WAIT_STATES+1 cycles after the edge that sampled the request, for exactly one cycle.
REQ-019 RESP SHALL always return to IDLE, so back-to-back requests SHALL be acked at most once every WAIT_STATES+2 cycles.
REQ-020 A request is in range when bus__adr[29:DEPTH_LOG2] equals BASE[29:DEPTH_LOG2]; the word index is bus__adr[DEPTH_LOG2-1:0].
REQ-021 An in-range write SHALL update only the selected byte lanes on the edge that enters RESP; sel=0 SHALL ack with no change.
REQ-022 An in-range read SHALL load bus__dat_r from the addressed word on the edge entering RESP.
REQ-023 Outside RESP, bus__dat_r SHALL be 0.
REQ-024 Address, we, sel and dat_w SHALL be sampled on the edge entering RESP; the initiator holds them stable from request to ack.
REQ-025 If bus__cyc or bus__stb drops during WAIT, the FSM SHALL return to IDLE with no ack and no write.
REQ-026 Memory contents SHALL NOT be reset or initialised.

Reset
REQ-027 On rst assertion, asynchronously: state IDLE, counter 0, bus__ack 0, bus__dat_r 0.
REQ-028 A write whose RESP edge has not yet occurred SHALL NOT commit if rst asserts first.
REQ-029 The first request SHALL be sampled on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro WB_ERR_EN SHALL add output port bus__err (1 bit, registered, reset 0).
REQ-031 With WB_ERR_EN defined, an out-of-range request SHALL assert bus__err instead of bus__ack, with the same timing, dat_r 0 and no write.
REQ-032 Without WB_ERR_EN, bus__err SHALL be absent, and out-of-range requests SHALL ack normally with dat_r 0 and writes dropped.
REQ-033 In all builds, ack and err SHALL never both be 1.

Verification
REQ-034 WAIT_STATES=2: write 0xDEADBEEF to adr 5 with sel=0xF, then read adr 5 -> each ack arrives 3 cycles after its request; read dat_r=0xDEADBEEF.
REQ-035 Write 0x11223344 with sel=0x5 over an existing word 0xDEADBEEF -> readback is 0xDE22BE44.
REQ-036 WAIT_STATES=0 with cyc/stb held high for 6 cycles -> ack pattern 010101; dat_r is 0 on every non-ack cycle.
REQ-037 Drop stb on the cycle after the request, WAIT_STATES=2 -> no ack; the addressed word is unchanged.
REQ-038 Assert rst during WAIT of a write -> ack stays 0; memory is unchanged; the next read of that address returns the old value.
REQ-039 With WB_ERR_EN defined, read adr 0x400 (DEPTH_LOG2=10, BASE=0) -> err pulses after 3 cycles, ack stays 0, dat_r=0; without WB_ERR_EN -> ack pulses and dat_r=0.
